// File: rtl/sig_mux_pkg.sv
// Shared types and helpers for the break-before-make signal selector.
// Holds the LIVE/GAP state encoding, a constant clog2, and the default idle value.
package sig_mux_pkg;

    typedef enum logic {
        LIVE = 1'b0,
        GAP  = 1'b1
    } state_t;

    localparam int IDLE_VAL_DEFAULT = 0;

    function automatic int clog2(input int value);
        int bits;
        int v;
        bits = 0;
        v    = value - 1;
        while (v > 0) begin
            bits++;
            v = v >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/sig_mux_dwell_tmr.sv
// Dwell timer for auto-scan: counts LIVE cycles and pulses scan_req on the
// last cycle of each dwell period.
module sig_mux_dwell_tmr
    import sig_mux_pkg::*;
#(
    parameter int DWELL = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scan_en,
    input  logic live,
    input  logic clear,
    output logic scan_req
);

    localparam int CNT_W = clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] dwell_cnt;

    assign scan_req = scan_en && live && (dwell_cnt == LAST);

    // NOTE: reset is sampled on the clock edge only; every state update uses <=
    // so all flops see the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dwell_cnt <= '0;
        end else if (!scan_en || clear) begin
            dwell_cnt <= '0;
        end else if (live) begin
            dwell_cnt <= scan_req ? '0 : dwell_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sig_mux_bbm.sv
// N-channel, W-bit selector with break-before-make switching: the registered
// output idles for GAP_CYCLES cycles between channels; optional auto-scan.
module sig_mux_bbm
    import sig_mux_pkg::*;
#(
    parameter int             N          = 4,
    parameter int             W          = 1,
    parameter int             SEL_W      = 2,
    parameter int             GAP_CYCLES = 2,
    parameter logic [W-1:0]   IDLE_VAL   = W'(IDLE_VAL_DEFAULT),
    parameter int             DWELL      = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*W-1:0]     in_bus,
    input  logic               wr,
    input  logic [SEL_W-1:0]   data_wr,
    input  logic               scan_en,
    output logic [W-1:0]       out,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               busy,
    output logic               sel_err
);

    localparam int               NSLOT    = 1 << SEL_W;
    localparam logic [SEL_W:0]   N_LIM    = (SEL_W + 1)'(N);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N - 1);
    localparam logic [7:0]       GAP_LOAD = 8'(GAP_CYCLES - 1);

    state_t           state, state_d;
    logic [SEL_W-1:0] pend, pend_d, cur_sel_d, target, scan_next;
    logic [7:0]       gap_cnt, gap_d;
    logic [W-1:0]     out_d;
    logic             busy_d, sel_err_d;
    logic             wr_ok, scan_req, dwell_clr, live;

    // Unused select codes read the idle value, so any SEL_W-bit index is safe.
    logic [W-1:0] chan [NSLOT];
    for (genvar k = 0; k < NSLOT; k++) begin : g_chan
        if (k < N) begin : g_used
            assign chan[k] = in_bus[k*W +: W];
        end else begin : g_unused
            assign chan[k] = IDLE_VAL;
        end
    end

    assign wr_ok     = wr && ({1'b0, data_wr} < N_LIM);
    assign scan_next = (cur_sel == LAST_CH) ? '0 : cur_sel + SEL_W'(1);
    assign live      = (state == LIVE);

    sig_mux_dwell_tmr #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .scan_en  (scan_en),
        .live     (live),
        .clear    (dwell_clr),
        .scan_req (scan_req)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d   = state;
        cur_sel_d = cur_sel;
        pend_d    = pend;
        gap_d     = gap_cnt;
        out_d     = out;
        busy_d    = busy;
        dwell_clr = 1'b0;
        sel_err_d = wr && !wr_ok;
        target    = wr_ok ? data_wr : scan_next;

        case (state)
            LIVE: begin
                out_d = chan[cur_sel];
                if (wr_ok || scan_req) begin
                    if (target == cur_sel) begin
                        dwell_clr = 1'b1;
                    end else if (GAP_CYCLES == 0) begin
                        cur_sel_d = target;
                        out_d     = chan[target];
                        dwell_clr = 1'b1;
                    end else begin
                        pend_d  = target;
                        gap_d   = GAP_LOAD;
                        state_d = GAP;
                        busy_d  = 1'b1;
                        out_d   = IDLE_VAL;
                    end
                end
            end
            GAP: begin
                out_d = IDLE_VAL;
                if (wr_ok) pend_d = data_wr;
                // A write on the final gap cycle still wins: connect pend_d, not pend.
                if (gap_cnt == 8'd0) begin
                    cur_sel_d = pend_d;
                    state_d   = LIVE;
                    busy_d    = 1'b0;
                    out_d     = chan[pend_d];
                    dwell_clr = 1'b1;
                end else begin
                    gap_d = gap_cnt - 8'd1;
                end
            end
            default: state_d = LIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= LIVE;
            cur_sel <= '0;
            pend    <= '0;
            gap_cnt <= '0;
            out     <= IDLE_VAL;
            busy    <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            state   <= state_d;
            cur_sel <= cur_sel_d;
            pend    <= pend_d;
            gap_cnt <= gap_d;
            out     <= out_d;
            busy    <= busy_d;
            sel_err <= sel_err_d;
        end
    end

endmodule

// File: tb/tb_sig_mux_bbm.sv
// Self-checking bench for sig_mux_bbm: three configurations (gap 2, gap 0 with
// N=3, gap 1 with scan) checked cycle by cycle through an expectation queue.
module tb_sig_mux_bbm;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_bus;

    logic        wr_a, wr_b, wr_c;
    logic [1:0]  data_a, data_b, data_c;
    logic        scan_a, scan_b, scan_c;

    logic [7:0]  out_a, out_b, out_c;
    logic [1:0]  sel_a, sel_b, sel_c;
    logic        busy_a, busy_b, busy_c;
    logic        err_a, err_b, err_c;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        int          dut;
        logic [15:0] exp;
    } exp_t;

    exp_t sb_q[$];

    sig_mux_bbm #(.N(4), .W(8), .SEL_W(2), .GAP_CYCLES(2), .DWELL(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .wr(wr_a), .data_wr(data_a),
        .scan_en(scan_a), .out(out_a), .cur_sel(sel_a), .busy(busy_a), .sel_err(err_a)
    );

    sig_mux_bbm #(.N(3), .W(8), .SEL_W(2), .GAP_CYCLES(0), .DWELL(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus[23:0]), .wr(wr_b), .data_wr(data_b),
        .scan_en(scan_b), .out(out_b), .cur_sel(sel_b), .busy(busy_b), .sel_err(err_b)
    );

    sig_mux_bbm #(.N(4), .W(8), .SEL_W(2), .GAP_CYCLES(1), .DWELL(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .wr(wr_c), .data_wr(data_c),
        .scan_en(scan_c), .out(out_c), .cur_sel(sel_c), .busy(busy_c), .sel_err(err_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {out[7:0], cur_sel[3:0], 2'b00, busy, sel_err}
    function automatic logic [15:0] pk(input logic [7:0] o, input logic [3:0] s,
                                       input logic b, input logic e);
        return {o, s, 2'b00, b, e};
    endfunction

    function automatic logic [15:0] obs(input int d);
        case (d)
            0:       return pk(out_a, {2'b00, sel_a}, busy_a, err_a);
            1:       return pk(out_b, {2'b00, sel_b}, busy_b, err_b);
            default: return pk(out_c, {2'b00, sel_c}, busy_c, err_c);
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got out/sel/busy/err=%h expected %h", tag, got, exp);
        end
    endtask

    // Queue the expectation with the stimulus, then compare after the edge.
    task automatic cyc(input int d, input string tag, input logic [15:0] e);
        exp_t item;
        item.tag = tag;
        item.dut = d;
        item.exp = e;
        sb_q.push_back(item);
        @(posedge clk);
        #1;
        item = sb_q.pop_front();
        check(item.tag, obs(item.dut), item.exp);
    endtask

    initial begin
        rst_n  = 1'b0;
        in_bus = {8'hC3, 8'h77, 8'h11, 8'hA5};
        wr_a = 1'b0; wr_b = 1'b0; wr_c = 1'b0;
        data_a = '0; data_b = '0; data_c = '0;
        scan_a = 1'b0; scan_b = 1'b0; scan_c = 1'b0;

        // Reset and live path
        repeat (3) cyc(0, "rst", pk(8'h00, 0, 0, 0));
        rst_n = 1'b1;
        #1 check("rel_idle", obs(0), pk(8'h00, 0, 0, 0));
        cyc(0, "live_ch0", pk(8'hA5, 0, 0, 0));
        in_bus[7:0] = 8'h3C;
        cyc(0, "live_upd", pk(8'h3C, 0, 0, 0));

        // Write to the connected channel: no gap
        wr_a = 1'b1; data_a = 2'd0;
        cyc(0, "noop_a", pk(8'h3C, 0, 0, 0));
        wr_a = 1'b0;
        cyc(0, "noop_a_hold", pk(8'h3C, 0, 0, 0));

        // Break-before-make 0 -> 2
        wr_a = 1'b1; data_a = 2'd2;
        cyc(0, "bbm_gap1", pk(8'h00, 0, 1, 0));
        wr_a = 1'b0;
        cyc(0, "bbm_gap2", pk(8'h00, 0, 1, 0));
        cyc(0, "bbm_done", pk(8'h77, 2, 0, 0));
        cyc(0, "bbm_live", pk(8'h77, 2, 0, 0));

        // Last write wins: request 1, overwrite with 3 in the second gap cycle
        wr_a = 1'b1; data_a = 2'd1;
        cyc(0, "lww_gap1", pk(8'h00, 2, 1, 0));
        wr_a = 1'b0;
        cyc(0, "lww_gap2", pk(8'h00, 2, 1, 0));
        wr_a = 1'b1; data_a = 2'd3;
        cyc(0, "lww_done", pk(8'hC3, 3, 0, 0));
        wr_a = 1'b0;
        cyc(0, "lww_live", pk(8'hC3, 3, 0, 0));

        // Write of the old channel mid-gap: gap neither aborts nor restarts
        wr_a = 1'b1; data_a = 2'd0;
        cyc(0, "noabort_gap1", pk(8'h00, 3, 1, 0));
        data_a = 2'd3;
        cyc(0, "noabort_gap2", pk(8'h00, 3, 1, 0));
        wr_a = 1'b0;
        cyc(0, "noabort_done", pk(8'hC3, 3, 0, 0));

        // Reset in the middle of a gap
        wr_a = 1'b1; data_a = 2'd1;
        cyc(0, "rgap_gap1", pk(8'h00, 3, 1, 0));
        wr_a = 1'b0; rst_n = 1'b0;
        cyc(0, "rgap_rst", pk(8'h00, 0, 0, 0));
        rst_n = 1'b1;
        cyc(0, "rgap_live", pk(8'h3C, 0, 0, 0));
        cyc(0, "rgap_hold", pk(8'h3C, 0, 0, 0));

        // N=3, no gap: invalid write, no-op write, immediate switch
        cyc(1, "b_live", pk(8'h3C, 0, 0, 0));
        wr_b = 1'b1; data_b = 2'd3;
        cyc(1, "b_err", pk(8'h3C, 0, 0, 1));
        wr_b = 1'b0;
        cyc(1, "b_err_clr", pk(8'h3C, 0, 0, 0));
        wr_b = 1'b1; data_b = 2'd0;
        cyc(1, "b_noop", pk(8'h3C, 0, 0, 0));
        data_b = 2'd2;
        cyc(1, "b_nogap", pk(8'h77, 2, 0, 0));
        wr_b = 1'b0; in_bus[23:16] = 8'h5A;
        cyc(1, "b_follow", pk(8'h5A, 2, 0, 0));

        // Scan wrap 3 -> 0 with a one-cycle gap
        wr_c = 1'b1; data_c = 2'd3;
        cyc(2, "c_gap", pk(8'h00, 0, 1, 0));
        wr_c = 1'b0;
        cyc(2, "c_to3", pk(8'hC3, 3, 0, 0));
        scan_c = 1'b1;
        for (int i = 0; i < 7; i++) cyc(2, "scan_dwell", pk(8'hC3, 3, 0, 0));
        cyc(2, "scan_gap", pk(8'h00, 3, 1, 0));
        cyc(2, "scan_wrap", pk(8'h3C, 0, 0, 0));

        // Write on the dwell-expiry cycle beats the scan target
        scan_c = 1'b0; wr_c = 1'b1; data_c = 2'd3;
        cyc(2, "c_gap_b", pk(8'h00, 0, 1, 0));
        wr_c = 1'b0;
        cyc(2, "c_to3_b", pk(8'hC3, 3, 0, 0));
        scan_c = 1'b1;
        for (int i = 0; i < 7; i++) cyc(2, "prio_dwell", pk(8'hC3, 3, 0, 0));
        wr_c = 1'b1; data_c = 2'd1;
        cyc(2, "prio_gap", pk(8'h00, 3, 1, 0));
        wr_c = 1'b0; scan_c = 1'b0;
        cyc(2, "prio_win", pk(8'h11, 1, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
